// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard controller for a five-stage in-order pipeline. Each cycle it
// decides which pipeline latches advance, where bubbles are injected, and
// whether the machine is frozen by a halt. It counts stall and flush events
// in saturating counters.
//
// Ports
//   CLK          in   system clock, all state updates on the rising edge
//   nRST         in   synchronous active-low reset
//   ihit         in   instruction fetch completes this cycle
//   dhit         in   data access completes this cycle
//   mem_dREN     in   EX/MEM latched data read request
//   mem_dWEN     in   EX/MEM latched data write request
//   ex_dREN      in   ID/EX latched load flag
//   ex_RegWr     in   ID/EX latched register-write enable
//   ex_wsel[4:0] in   ID/EX latched destination register
//   id_rs[4:0]   in   decode-stage rs source register
//   id_rt[4:0]   in   decode-stage rt source register
//   id_uses_rt   in   decode-stage instruction reads rt
//   ex_taken     in   EX-stage jump/branch redirects the PC this cycle
//   mem_halt     in   halt instruction has reached the MEM stage
//   pc_en        out  PC advance enable
//   ifid_en      out  IF/ID latch enable
//   idex_en      out  ID/EX latch enable
//   exmem_en     out  EX/MEM latch enable
//   memwb_en     out  MEM/WB latch enable
//   ifid_flush   out  load a bubble into IF/ID on the edge
//   idex_flush   out  load a bubble into ID/EX on the edge
//   halted       out  pipeline frozen by halt (registered)
//   stall_cnt    out  saturating stall-event counter (registered)
//   flush_cnt    out  saturating flush-event counter (registered)
//
// Latch enables and flushes are combinational from the state and the inputs
// so that a hazard is acted on in the same cycle it is detected.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             ex_dREN,
    input  logic             ex_RegWr,
    input  logic [4:0]       ex_wsel,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_taken,
    input  logic             mem_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        MEMWAIT = 2'b01,
        LUBUB   = 2'b10,
        HALT    = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_r;
    state_t           next_state_s;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;
    logic             halted_r;

    logic             mem_busy_s;
    logic             lu_haz_s;
    logic             stall_inc_s;
    logic             flush_inc_s;

    logic             pc_en_s;
    logic             ifid_en_s;
    logic             idex_en_s;
    logic             exmem_en_s;
    logic             memwb_en_s;
    logic             ifid_flush_s;
    logic             idex_flush_s;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        if (val == CNT_MAX) begin
            sat_inc = val;
        end else begin
            sat_inc = val + CNT_ONE;
        end
    endfunction

    // Data memory still owes a response for the access sitting in MEM.
    assign mem_busy_s = (mem_dREN | mem_dWEN) & ~dhit;

    // Load in EX writes a register that the instruction in decode reads.
    // Register 0 is hard-wired, so a load targeting it never hazards.
    assign lu_haz_s = ex_dREN & ex_RegWr & (ex_wsel != 5'd0) &
                      ((ex_wsel == id_rs) | (id_uses_rt & (ex_wsel == id_rt)));

    // Per-cycle hazard resolution: enables, flushes, next state, counter events.
    always_comb begin
        pc_en_s      = 1'b0;
        ifid_en_s    = 1'b0;
        idex_en_s    = 1'b0;
        exmem_en_s   = 1'b0;
        memwb_en_s   = 1'b0;
        ifid_flush_s = 1'b0;
        idex_flush_s = 1'b0;
        stall_inc_s  = 1'b0;
        flush_inc_s  = 1'b0;
        next_state_s = state_r;

        if (!nRST) begin
            // Everything held off while reset is asserted.
            next_state_s = RUN;
        end else if ((state_r == HALT) || mem_halt) begin
            // Frozen; only reset leaves this state.
            next_state_s = HALT;
        end else if (state_r == MEMWAIT) begin
            // Every cycle spent waiting on data memory counts as a stall,
            // including the cycle the response arrives.
            stall_inc_s = 1'b1;
            if (dhit) begin
                exmem_en_s   = 1'b1;
                memwb_en_s   = 1'b1;
                idex_en_s    = ihit;
                ifid_en_s    = ihit;
                pc_en_s      = ihit;
                next_state_s = RUN;
            end else begin
                next_state_s = MEMWAIT;
            end
        end else if (mem_busy_s) begin
            // Whole pipeline holds until the data access completes.
            next_state_s = MEMWAIT;
        end else if (ex_taken) begin
            pc_en_s      = 1'b1;
            idex_en_s    = 1'b1;
            idex_flush_s = 1'b1;
            exmem_en_s   = 1'b1;
            memwb_en_s   = 1'b1;
            next_state_s = RUN;
            if (ihit) begin
                // Squash both wrong-path instructions behind the branch.
                ifid_en_s    = 1'b1;
                ifid_flush_s = 1'b1;
                flush_inc_s  = 1'b1;
            end else begin
                // Fetch still pending: keep IF/ID, count the flush only once
                // the redirect actually completes with a fetch.
                ifid_en_s    = 1'b0;
                ifid_flush_s = 1'b0;
                flush_inc_s  = 1'b0;
            end
        end else if (lu_haz_s && (state_r == RUN)) begin
            // Hold PC and decode, push a bubble into EX for one cycle.
            idex_en_s    = 1'b1;
            idex_flush_s = 1'b1;
            exmem_en_s   = 1'b1;
            memwb_en_s   = 1'b1;
            stall_inc_s  = 1'b1;
            next_state_s = LUBUB;
        end else begin
            // Normal flow. LUBUB also lands here: the bubble has already
            // separated the load from its consumer, so lu_haz is ignored.
            pc_en_s      = ihit;
            ifid_en_s    = ihit;
            idex_en_s    = 1'b1;
            idex_flush_s = ~ihit;
            exmem_en_s   = 1'b1;
            memwb_en_s   = 1'b1;
            next_state_s = RUN;
        end
    end

    // State register, halt flag and saturating event counters.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_r     <= RUN;
            halted_r    <= 1'b0;
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r  <= next_state_s;
            halted_r <= (next_state_s == HALT);
            if (stall_inc_s) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush_inc_s) begin
                flush_cnt_r <= sat_inc(flush_cnt_r);
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign pc_en      = pc_en_s;
    assign ifid_en    = ifid_en_s;
    assign idex_en    = idex_en_s;
    assign exmem_en   = exmem_en_s;
    assign memwb_en   = memwb_en_s;
    assign ifid_flush = ifid_flush_s;
    assign idex_flush = idex_flush_s;
    assign halted     = halted_r;
    assign stall_cnt  = stall_cnt_r;
    assign flush_cnt  = flush_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Directed bench for hazard_ctrl. A default-width instance and a CNT_W=2
// instance share all inputs; the narrow one shows counter saturation.
// Enable/flush vectors are packed as
//   {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush}.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    logic        CLK;
    logic        nRST;
    logic        ihit;
    logic        dhit;
    logic        mem_dREN;
    logic        mem_dWEN;
    logic        ex_dREN;
    logic        ex_RegWr;
    logic [4:0]  ex_wsel;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        ex_taken;
    logic        mem_halt;

    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, halted;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en;
    logic        s_ifid_flush, s_idex_flush, s_halted;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int tests = 0;
    int fails = 0;

    localparam logic [6:0] EN_NONE   = 7'b0000000;
    localparam logic [6:0] EN_NORM   = 7'b1111100;
    localparam logic [6:0] EN_BUBBLE = 7'b0011101;
    localparam logic [6:0] EN_TAKEN  = 7'b1111111;
    localparam logic [6:0] EN_TKWAIT = 7'b1011101;
    localparam logic [6:0] EN_MEMREL = 7'b0001100;

    hazard_ctrl u_dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
        .ex_dREN(ex_dREN), .ex_RegWr(ex_RegWr), .ex_wsel(ex_wsel),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_taken(ex_taken), .mem_halt(mem_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctrl #(.CNT_W(2)) u_sat (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
        .ex_dREN(ex_dREN), .ex_RegWr(ex_RegWr), .ex_wsel(ex_wsel),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_taken(ex_taken), .mem_halt(mem_halt),
        .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en),
        .exmem_en(s_exmem_en), .memwb_en(s_memwb_en),
        .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
        .halted(s_halted), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr_in();
        ihit       = 1'b0;
        dhit       = 1'b0;
        mem_dREN   = 1'b0;
        mem_dWEN   = 1'b0;
        ex_dREN    = 1'b0;
        ex_RegWr   = 1'b0;
        ex_wsel    = 5'd0;
        id_rs      = 5'd0;
        id_rt      = 5'd0;
        id_uses_rt = 1'b0;
        ex_taken   = 1'b0;
        mem_halt   = 1'b0;
    endtask

    task automatic load_use_rs5();
        ex_dREN  = 1'b1;
        ex_RegWr = 1'b1;
        ex_wsel  = 5'd5;
        id_rs    = 5'd5;
    endtask

    task automatic chk_en(input string tag, input logic [6:0] exp);
        logic [6:0] obs;
        obs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        clr_in();
        nRST = 1'b0;
        ihit = 1'b1;
        tick();
        // Reset state
        chk_en("rst_en", EN_NONE);
        chk_val("rst_stall", 32'(stall_cnt), 32'd0);
        chk_val("rst_flush", 32'(flush_cnt), 32'd0);
        chk_val("rst_halted", 32'(halted), 32'd0);

        // Normal flow with and without a fetch
        nRST = 1'b1;
        #1 chk_en("norm_ihit", EN_NORM);
        tick();
        chk_val("norm_stall", 32'(stall_cnt), 32'd0);
        chk_val("norm_flush", 32'(flush_cnt), 32'd0);
        ihit = 1'b0;
        #1 chk_en("norm_noihit", EN_BUBBLE);
        tick();

        // Load-use on rs: one stall cycle then one LUBUB cycle
        ihit = 1'b1;
        load_use_rs5();
        #1 chk_en("lu_stall", EN_BUBBLE);
        tick();
        chk_val("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        chk_en("lu_lubub", EN_NORM);
        tick();
        chk_val("lu_after_lubub", 32'(stall_cnt), 32'd1);

        // Destination register 0 never hazards
        ex_wsel = 5'd0;
        id_rs   = 5'd0;
        #1 chk_en("lu_wsel0", EN_NORM);

        // rt match only hazards when rt is actually read
        ex_wsel    = 5'd7;
        id_rs      = 5'd1;
        id_rt      = 5'd7;
        id_uses_rt = 1'b0;
        #1 chk_en("lu_rt_unused", EN_NORM);
        id_uses_rt = 1'b1;
        #1 chk_en("lu_rt_used", EN_BUBBLE);
        tick();
        chk_val("lu_rt_cnt", 32'(stall_cnt), 32'd2);
        clr_in();
        ihit = 1'b1;
        tick();

        // Data memory wait: 3 frozen cycles, release on the dhit cycle
        mem_dREN = 1'b1;
        #1 chk_en("mem_busy", EN_NONE);
        tick();
        chk_en("memwait_1", EN_NONE);
        tick();
        chk_en("memwait_2", EN_NONE);
        tick();
        dhit = 1'b1;
        ihit = 1'b0;
        #1 chk_en("mem_release", EN_MEMREL);
        tick();
        chk_val("mem_stall_cnt", 32'(stall_cnt), 32'd5);
        clr_in();
        ihit     = 1'b1;
        mem_dWEN = 1'b1;
        dhit     = 1'b1;
        #1 chk_en("dwen_hit", EN_NORM);
        tick();

        // Branch taken wins over a simultaneous load-use hazard
        clr_in();
        ihit     = 1'b1;
        ex_taken = 1'b1;
        load_use_rs5();
        #1 chk_en("taken_lu", EN_TAKEN);
        tick();
        chk_val("taken_flush_cnt", 32'(flush_cnt), 32'd1);
        chk_val("taken_stall_cnt", 32'(stall_cnt), 32'd5);

        // Branch taken while the fetch is still outstanding
        clr_in();
        ex_taken = 1'b1;
        #1 chk_en("taken_noihit", EN_TKWAIT);
        tick();
        chk_val("taken_wait_cnt", 32'(flush_cnt), 32'd1);
        ihit = 1'b1;
        #1 chk_en("taken_ihit", EN_TAKEN);
        tick();
        chk_val("taken_done_cnt", 32'(flush_cnt), 32'd2);

        // Reset clears a pending memory wait and the counters
        clr_in();
        ihit     = 1'b1;
        mem_dREN = 1'b1;
        tick();
        nRST = 1'b0;
        #1 chk_en("rst_memwait_en", EN_NONE);
        tick();
        nRST = 1'b1;
        clr_in();
        ihit = 1'b1;
        #1 chk_en("post_rst_memwait", EN_NORM);
        chk_val("post_rst_stall", 32'(stall_cnt), 32'd0);
        chk_val("post_rst_flush", 32'(flush_cnt), 32'd0);
        tick();

        // Five load-use events: wide counter 5, 2-bit counter saturates at 3
        load_use_rs5();
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        chk_val("sat_wide_cnt", 32'(stall_cnt), 32'd5);
        chk_val("sat_narrow_cnt", 32'(s_stall_cnt), 32'd3);

        // Halt freezes everything until reset
        clr_in();
        ihit     = 1'b1;
        mem_halt = 1'b1;
        #1 chk_en("halt_en", EN_NONE);
        tick();
        chk_val("halt_flag", 32'(halted), 32'd1);
        mem_halt = 1'b0;
        #1 chk_en("halt_hold", EN_NONE);
        tick();
        ex_taken = 1'b1;
        #1 chk_en("halt_taken", EN_NONE);
        chk_val("halt_flag_hold", 32'(halted), 32'd1);
        chk_val("halt_flush_cnt", 32'(flush_cnt), 32'd0);
        tick();
        nRST = 1'b0;
        #1 chk_en("halt_rst_en", EN_NONE);
        tick();
        chk_val("halt_cleared", 32'(halted), 32'd0);
        nRST = 1'b1;
        clr_in();
        ihit = 1'b1;
        #1 chk_en("halt_resume", EN_NORM);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
